dff_shift_ctrl: RTL and testbench

Sequencing controller for a WIDTH-bit register bank built from positive-edge D flip-flops. On a start pulse it parallel-loads a word into the bank. It then shifts the word out serially, MSB first, while capturing a serial input word into a second bank. It reports completion with a one-cycle pulse. It sits between a parallel host side and a single-bit serial link or loopback path, and owns all load/shift/capture enables of the flip-flop datapath.

---
 rtl/dff_shift_ctrl.sv | 91 +++++++++
 tb/tb_dff_shift_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/dff_shift_ctrl.sv
// Load/shift/capture sequencer for a WIDTH-bit flip-flop bank: parallel load on start,
// MSB-first serial shift-out with simultaneous serial capture, one-cycle done pulse.
module dff_shift_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_hold,
  input  logic             i_sdi,
  output logic             o_sdo,
  output logic             o_sdo_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_dout
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-2:0] r_cap;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dout;
  logic             r_busy;
  logic             r_done;

  // The capture bank keeps only WIDTH-1 bits; the completing edge forms the full word.
  logic [WIDTH-1:0] w_cap_next;
  logic             w_last;

  assign w_cap_next = {r_cap, i_sdi};
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_shreg <= '0;
      r_cap   <= '0;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_shreg <= i_din;
            r_cap   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= StShift;
          end
        end
        StShift: begin
          if (!i_hold) begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            r_cap   <= w_cap_next[WIDTH-2:0];
            if (w_last) begin
              r_cnt   <= '0;
              r_dout  <= w_cap_next;
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_sdo       = (r_state == StShift) & r_shreg[WIDTH-1];
  assign o_sdo_valid = (r_state == StShift) & ~i_hold;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_dout      = r_dout;

endmodule

// File: tb/tb_dff_shift_ctrl.sv
// Directed bench for dff_shift_ctrl (WIDTH=8): reset, loopback, independent serial in,
// hold stalls, ignored start and mid-transfer reset.
module tb_dff_shift_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, hold, sdi_drv, lb;
  logic [7:0] din;
  logic       sdi;
  logic       sdo, sdo_valid, busy, done;
  logic [7:0] dout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign sdi = lb ? sdo : sdi_drv;

  dff_shift_ctrl #(.WIDTH(8)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_din      (din),
    .i_hold     (hold),
    .i_sdi      (sdi),
    .o_sdo      (sdo),
    .o_sdo_valid(sdo_valid),
    .o_busy     (busy),
    .o_done     (done),
    .o_dout     (dout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transfer. Holds are applied for hold_len cycles once hold_at bits have gone out.
  task automatic xfer(input string tag, input logic [7:0] d, input bit loop,
                      input logic [7:0] sdi_pat, input int hold_at, input int hold_len,
                      input bit keep_start, input logic [7:0] exp_dout);
    int         k = 0;
    int         cyc = 0;
    int         held = 0;
    bit         h;
    logic [7:0] prev_dout;
    logic [7:0] nd;
    nd        = ~d;
    prev_dout = dout;
    lb        = loop;
    din       = d;
    start     = 1'b1;
    tick();
    start = keep_start;
    if (keep_start) din = nd;
    check_eq({tag, "_busy_e0"}, busy, 1);
    while (k < 8 && cyc < 40) begin
      h       = (k == hold_at) && (held < hold_len);
      hold    = h;
      sdi_drv = sdi_pat[7-k];
      #1;
      check_eq($sformatf("%s_sdo%0d", tag, cyc), sdo, d[7-k]);
      check_eq($sformatf("%s_vld%0d", tag, cyc), sdo_valid, !h);
      check_eq($sformatf("%s_nodone%0d", tag, cyc), done, 0);
      check_eq($sformatf("%s_douthold%0d", tag, cyc), dout, prev_dout);
      tick();
      cyc++;
      if (h) held++;
      else k++;
    end
    hold = 1'b0;
    check_eq({tag, "_latency"}, cyc, 8 + hold_len);
    check_eq({tag, "_done"}, done, 1);
    check_eq({tag, "_busy_done"}, busy, 1);
    check_eq({tag, "_sdo_done"}, sdo, 0);
    check_eq({tag, "_dout"}, dout, exp_dout);
    tick();
    check_eq({tag, "_done_fall"}, done, 0);
    check_eq({tag, "_busy_fall"}, busy, 0);
    check_eq({tag, "_dout_keep"}, dout, exp_dout);
    if (keep_start) begin
      tick();
      check_eq({tag, "_restart_busy"}, busy, 1);
      check_eq({tag, "_restart_sdo"}, sdo, nd[7]);
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'($urandom_range(0, 1));
    hold    = 1'($urandom_range(0, 1));
    sdi_drv = 1'($urandom_range(0, 1));
    lb      = 1'b0;
    din     = 8'($urandom);
    tick();
    start = 1'b1;
    din   = 8'($urandom);
    tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_sdo", sdo, 0);
    check_eq("rst_vld", sdo_valid, 0);
    check_eq("rst_dout", dout, 0);
    rst   = 1'b0;
    start = 1'b0;
    hold  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("idle_busy%0d", i), busy, 0);
    end

    xfer("lb_a5", 8'hA5, 1'b1, 8'h00, -1, 0, 1'b0, 8'hA5);
    xfer("ser_3c", 8'h3C, 1'b0, 8'b1100_0001, -1, 0, 1'b0, 8'hC1);
    xfer("hold_f0", 8'hF0, 1'b1, 8'h00, 2, 3, 1'b0, 8'hF0);

    // Start held through the whole transfer: the next one begins only from IDLE.
    xfer("ign_96", 8'h96, 1'b1, 8'h00, -1, 0, 1'b1, 8'h96);
    start = 1'b0;
    for (int i = 0; i < 20 && busy; i++) tick();
    check_eq("ign_second_end", busy, 0);
    check_eq("ign_second_dout", dout, 8'h69);

    lb    = 1'b1;
    din   = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("mrst_pre_sdo", sdo, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_sdo", sdo, 0);
    check_eq("mrst_dout", dout, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq($sformatf("mrst_nodone%0d", i), done, 0);
    end
    xfer("after_5a", 8'h5A, 1'b1, 8'h00, -1, 0, 1'b0, 8'h5A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
